shift_reg_univ: RTL

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_univ_pkg.sv | 25 ++
 rtl/shift_reg_univ_counter.sv | 54 +++++
 rtl/shift_reg_univ.sv | 117 +++++++++++
 3 files changed

// File: rtl/shift_reg_univ_pkg.sv
// shift_reg_univ_pkg
// Shared definitions for the universal shift register and its word counter:
//   MODE_HOLD / MODE_SHL / MODE_SHR / MODE_LOAD : 2-bit operation select codes
//   clog2(value)                                : bits needed to count 0..value-1
package shift_reg_univ_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Returns at least 1 so a counter always has a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_univ_counter.sv
// shift_word_counter
// Counts shifts 0..W-1 and reports completion of every W-th shift.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (clears count and word_valid)
//   shift      : a shift happens at this edge (already qualified by enable)
//   clear      : parallel load at this edge; restarts the count
//   wrap       : combinational, this shift completes a word
//   word_valid : registered one-cycle pulse in the cycle after the wrapping shift
module shift_word_counter
    import shift_reg_univ_pkg::*;
#(
    parameter int W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic clear,
    output logic wrap,
    output logic word_valid
);

    localparam int CW = clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          word_valid_reg;

    assign wrap = shift && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (shift) begin
            count_next = wrap ? '0 : count_reg + CW'(1);
        end
    end

    // word_valid is rebuilt every edge, so hold / disabled cycles drop it to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            word_valid_reg <= wrap;
        end
    end

    assign word_valid = word_valid_reg;

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ
// Universal W-bit shift register: hold, shift left, shift right, parallel load,
// with a word-completion pulse and an optional pattern matcher.
// Build option: define SHIFT_PATTERN_MATCH_EN to compile in the filled flag and
// the q==PATTERN comparator; otherwise match is constant 0.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   en         : clock enable, 0 freezes all state
//   mode       : 00 hold, 01 shift left, 10 shift right, 11 parallel load
//   d          : serial data in
//   load_data  : parallel load word
//   q          : registered contents
//   sout       : q[W-1] in shift-left mode, else q[0] (combinational)
//   word_valid : one-cycle pulse when q first holds a complete shifted word
//   match      : filled and q == PATTERN
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int             W       = 5,
    parameter logic [W-1:0]   PATTERN = W'(5'b10010)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         d,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] q,
    output logic         sout,
    output logic         word_valid,
    output logic         match
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;
    logic [W-1:0] shl_word;
    logic [W-1:0] shr_word;
    logic         do_shift;
    logic         do_load;
    logic         wrap;

    assign do_shift = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
    assign do_load  = en && (mode == MODE_LOAD);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign shl_word[gi] = d;
            end else begin : g_lsb_n
                assign shl_word[gi] = q_reg[gi-1];
            end
            if (gi == W - 1) begin : g_msb
                assign shr_word[gi] = d;
            end else begin : g_msb_n
                assign shr_word[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (en) begin
            case (mode)
                MODE_SHL:  q_next = shl_word;
                MODE_SHR:  q_next = shr_word;
                MODE_LOAD: q_next = load_data;
                default:   q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    shift_word_counter #(
        .W (W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .shift      (do_shift),
        .clear      (do_load),
        .wrap       (wrap),
        .word_valid (word_valid)
    );

    assign q    = q_reg;
    assign sout = (mode == MODE_SHL) ? q_reg[W-1] : q_reg[0];

`ifdef SHIFT_PATTERN_MATCH_EN
    // filled: a full word has been shifted in or loaded since reset, so a
    // partially shifted register that happens to equal PATTERN is ignored.
    logic filled_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            filled_reg <= 1'b0;
        end else if (do_load || wrap) begin
            filled_reg <= 1'b1;
        end
    end

    assign match = filled_reg && (q_reg == PATTERN);
`else
    // Matcher compiled out; the port stays so both builds share one footprint.
    logic unused_match_inputs;
    assign unused_match_inputs = ^{PATTERN, wrap};
    assign match = 1'b0;
`endif

endmodule
